// File: rtl/ifetch_line_buf.sv
// Single-line instruction fetch buffer: one 512-bit line, miss fill over an 8-beat bus.
// Ports: core fetch (fetch_valid/addr/ready, flush, inst_valid/inst), bus req (reqcyc/reqack/req/reqtag),
// bus resp (respcyc/respack/resp/resptag). Macro IFETCH_CRITICAL_WORD_EN enables early critical-word return.

`ifndef SYSBUS_READ
`define SYSBUS_READ 1'b1
`endif
`ifndef SYSBUS_MEMORY
`define SYSBUS_MEMORY 4'b0001
`endif

module ifetch_line_buf #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      fetch_valid,
    input  logic [63:0]               fetch_addr,
    output logic                      fetch_ready,
    input  logic                      flush,
    output logic                      inst_valid,
    output logic [31:0]               inst,
    output logic                      reqcyc,
    input  logic                      reqack,
    output logic [BUS_DATA_WIDTH-1:0] req,
    output logic [BUS_TAG_WIDTH-1:0]  reqtag,
    input  logic                      respcyc,
    output logic                      respack,
    input  logic [BUS_DATA_WIDTH-1:0] resp,
    input  logic [BUS_TAG_WIDTH-1:0]  resptag
);

    typedef enum logic [2:0] {IDLE, HIT, REQ, FILL, DONE} state_t;

    localparam logic [12:0] READ_TAG = {`SYSBUS_READ, `SYSBUS_MEMORY, 8'h00};

    state_t       state_q, state_d;
    logic [61:0]  addr_q, addr_d;
    logic [511:0] line_q, line_d;
    logic [57:0]  tag_q, tag_d;
    logic         valid_q, valid_d;
    logic [2:0]   cnt_q, cnt_d;
    logic         flushed_q, flushed_d;
    logic         inst_valid_q, inst_valid_d;
    logic [31:0]  inst_q, inst_d;

    logic [63:0]  beat;
    logic         flush_seen;
    logic         unused_ok;

    assign beat       = 64'(resp);
    assign flush_seen = flushed_q | flush;
    assign unused_ok  = ^{resptag, fetch_addr[1:0]};

    function automatic logic [31:0] pick(input logic [511:0] l,
                                         input logic [2:0] b,
                                         input logic w);
        pick = l[{b, w, 5'b0} +: 32];
    endfunction

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        line_d       = line_q;
        tag_d        = tag_q;
        valid_d      = valid_q;
        cnt_d        = cnt_q;
        flushed_d    = flushed_q;
        inst_valid_d = 1'b0;
        inst_d       = inst_q;
        unique case (state_q)
            IDLE: begin
                if (flush) valid_d = 1'b0;
                if (fetch_valid) begin
                    addr_d    = fetch_addr[63:2];
                    flushed_d = 1'b0;
                    // A coincident flush forces a miss.
                    if (valid_q && !flush && tag_q == fetch_addr[63:6]) begin
                        state_d      = HIT;
                        inst_valid_d = 1'b1;
                        inst_d       = pick(line_q, fetch_addr[5:3], fetch_addr[2]);
                    end else begin
                        state_d = REQ;
                        // The line is about to be overwritten.
                        valid_d = 1'b0;
                    end
                end
            end
            HIT: begin
                if (flush) valid_d = 1'b0;
                state_d = IDLE;
            end
            REQ: begin
                if (flush) flushed_d = 1'b1;
                if (reqack) begin
                    state_d = FILL;
                    cnt_d   = 3'd0;
                end
            end
            FILL: begin
                if (flush) flushed_d = 1'b1;
                if (respcyc) begin
                    line_d[{cnt_q, 6'b0} +: 64] = beat;
                    cnt_d = cnt_q + 3'd1;
`ifdef IFETCH_CRITICAL_WORD_EN
                    if (cnt_q == addr_q[3:1] && !flush_seen) begin
                        inst_valid_d = 1'b1;
                        inst_d       = addr_q[0] ? beat[63:32] : beat[31:0];
                    end
`endif
                    if (cnt_q == 3'd7) begin
                        tag_d = addr_q[61:4];
                        if (flush_seen) begin
                            // Bus could not be aborted; discard the result.
                            state_d = IDLE;
                            valid_d = 1'b0;
                        end else begin
                            state_d = DONE;
                            valid_d = 1'b1;
`ifndef IFETCH_CRITICAL_WORD_EN
                            inst_valid_d = 1'b1;
                            inst_d       = pick(line_d, addr_q[3:1], addr_q[0]);
`endif
                        end
                    end
                end
            end
            DONE: begin
                if (flush) valid_d = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            line_q       <= '0;
            tag_q        <= '0;
            valid_q      <= 1'b0;
            cnt_q        <= 3'd0;
            flushed_q    <= 1'b0;
            inst_valid_q <= 1'b0;
            inst_q       <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            line_q       <= line_d;
            tag_q        <= tag_d;
            valid_q      <= valid_d;
            cnt_q        <= cnt_d;
            flushed_q    <= flushed_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
        end
    end

    assign fetch_ready = (state_q == IDLE);
    assign reqcyc      = (state_q == REQ);
    assign respack     = (state_q == FILL) & respcyc;
    assign req         = reqcyc ? BUS_DATA_WIDTH'({addr_q[61:4], 6'b0}) : '0;
    assign reqtag      = reqcyc ? BUS_TAG_WIDTH'(READ_TAG) : '0;
    assign inst_valid  = inst_valid_q;
    assign inst        = inst_q;

endmodule

// File: doc/ifetch_line_buf.md
IFETCH_LINE_BUF -- requirements
Module: ifetch_line_buf

Interface
REQ-001 SHALL have parameter BUS_DATA_WIDTH, default 64, width of bus request/response beats.
REQ-002 SHALL have parameter BUS_TAG_WIDTH, default 13, width of bus tags.
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  sole clock, all state updates on posedge.
REQ-005 reset  in  1  asynchronous active-low reset.
REQ-006 fetch_valid  in  1  core requests instruction at fetch_addr.
REQ-007 fetch_addr  in  64  instruction byte address; bits [1:0] ignored.
REQ-008 fetch_ready  out  1  block accepts a fetch this cycle.
REQ-009 flush  in  1  invalidate line buffer.
REQ-010 inst_valid  out  1  inst is valid, one-cycle pulse.
REQ-011 inst  out  32  fetched instruction.
REQ-012 reqcyc  out  1  bus request valid, to arbiter channel 0.
REQ-013 reqack  in  1  arbiter accepted request.
REQ-014 req  out  BUS_DATA_WIDTH  line-aligned request address.
REQ-015 reqtag  out  BUS_TAG_WIDTH  request tag.
REQ-016 respcyc  in  1  response beat valid.
REQ-017 respack  out  1  response beat consumed.
REQ-018 resp  in  BUS_DATA_WIDTH  response beat data.
REQ-019 resptag  in  BUS_TAG_WIDTH  response tag, not checked.

Function
REQ-020 SHALL hold one 512-bit line, a 58-bit line tag (addr[63:6]) and a valid bit.
REQ-021 SHALL implement states IDLE, HIT, REQ, FILL, DONE; fetch_ready=1 only in IDLE.
REQ-022 IDLE + fetch_valid: latch fetch_addr; go to HIT if valid and tag match, else REQ.
REQ-023 HIT: drive inst_valid=1 and inst from buffer; return to IDLE (hit latency 1 cycle after acceptance).
REQ-024 REQ: reqcyc=1, req={addr[63:6],6'b0}, reqtag={`SYSBUS_READ,`SYSBUS_MEMORY,8'h00}, all held stable until reqack sampled 1; then go to FILL, beat counter=0.
REQ-025 FILL: respack=respcyc (combinational, same cycle); each accepted beat i written to line bits [64i+63:64i], counter increments; after beat 7 go to DONE and set tag and valid.
REQ-026 DONE: inst_valid=1 with selected instruction; return to IDLE.
REQ-027 Instruction select: beat=addr[5:3], word=addr[2] (0 = low 32 bits).
REQ-028 Beat counter SHALL be 3 bits and wrap 7->0 at line completion.
REQ-029 Outside FILL, respack=0 and respcyc is ignored.
REQ-030 flush in IDLE/HIT: valid cleared next cycle; HIT still returns its instruction.
REQ-031 flush in REQ or FILL: transaction completes all 8 beats (bus is non-abortable), line written but valid left 0, no inst_valid, return to IDLE.
REQ-032 flush coincident with fetch_valid in IDLE: flush wins for valid; fetch treated as miss.

Reset
REQ-033 reset low: state=IDLE, valid=0, counter=0; outputs fetch_ready=1, inst_valid=0, inst=0, reqcyc=0, respack=0, req=0, reqtag=0.
REQ-034 Reset mid-FILL SHALL abandon the fill; valid=0 after release.

Configuration
REQ-035 Macro IFETCH_CRITICAL_WORD_EN SHALL select early return.
REQ-036 Defined: inst_valid pulses the cycle after the beat with index addr[5:3] is accepted, fill continues to 8 beats, DONE asserts no second inst_valid.
REQ-037 Undefined: inst_valid only in DONE per REQ-026.

Verification
REQ-038 Cold miss: fetch 0x1008, reqack after 3 cycles, beats 0..7 = 64'h(i)_(i) pattern -> one request, req=0x1000, inst = low word of beat 1, inst_valid one cycle after beat 7.
REQ-039 Hit: after REQ-038 fetch 0x103C -> no reqcyc, inst_valid next cycle, inst = high word of beat 7.
REQ-040 Backpressure: respcyc gapped (1 on, 2 off) -> respack only in respcyc cycles, line correct, counter wraps to 0.
REQ-041 Flush mid-FILL at beat 4 -> 8 beats still acked, no inst_valid, subsequent fetch 0x1000 misses.
REQ-042 Reset low during FILL beat 3 -> all outputs at reset values, next fetch 0x1000 misses.
REQ-043 With IFETCH_CRITICAL_WORD_EN, fetch 0x1010 -> inst_valid cycle after beat 2, exactly one pulse.
